lock_attempt_ctrl: RTL

LOCK_ATTEMPT_CTRL -- requirements
Module: lock_attempt_ctrl

---
 rtl/lock_attempt_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/lock_attempt_ctrl.sv
// Four-digit combination lock controller.
// It captures hex digits on the KEY3..KEY0 pulses, in that order.
// It checks or reprograms the stored password.
// It shows the result for a fixed time.
// After too many consecutive failures it locks the keypad out.
module lock_attempt_ctrl #(
  parameter logic [15:0] DEFAULT_PW    = 16'h01AF,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned RESULT_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES   = 500_000_000
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic [3:0]  USERIN,
  input  logic [3:0]  key_pulse,
  input  logic        mode_set,
  output logic [15:0] entry,
  output logic [15:0] stored_pw,
  output logic        ledg,
  output logic        ledr,
  output logic        armed,
  output logic        pw_updated,
  output logic [1:0]  fail_cnt,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_D3      = 3'd1,
    S_D2      = 3'd2,
    S_D1      = 3'd3,
    S_CHECK   = 3'd4,
    S_RESULT  = 3'd5,
    S_LOCKOUT = 3'd6
  } state_t;

  localparam logic [1:0]  MAX_FAIL_C    = 2'(MAX_FAIL);
  // The counter is loaded with N-1 and runs down to 0, so the state lasts N cycles.
  localparam logic [31:0] RESULT_RELOAD = 32'(RESULT_CYCLES - 1);
  localparam logic [31:0] LOCK_RELOAD   = 32'(LOCK_CYCLES - 1);

  state_t      state_q;
  logic [15:0] entry_q;
  logic [15:0] stored_pw_q;
  logic        armed_q;
  logic [1:0]  fail_cnt_q;
  logic        result_ok_q;
  logic [31:0] cnt_q;
  logic        prog_q;
  logic        pw_updated_q;
  logic        ledg_q;
  logic        ledr_q;

  logic [1:0]  fail_inc_d;
  logic        check_pass_d;

  // Saturating failure increment and the pass/fail verdict for the CHECK cycle.
  // Programming succeeds only while armed.
  // A plain check succeeds on an exact match.
  always_comb begin
    fail_inc_d   = (fail_cnt_q >= MAX_FAIL_C) ? MAX_FAIL_C : fail_cnt_q + 2'd1;
    check_pass_d = prog_q ? armed_q : (entry_q == stored_pw_q);
  end

  // Main FSM with registered outputs.
  // The LEDs are set on the transition into RESULT or LOCKOUT.
  // They are cleared on the transition out of those states.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q      <= S_IDLE;
      entry_q      <= 16'h0000;
      stored_pw_q  <= DEFAULT_PW;
      armed_q      <= 1'b0;
      fail_cnt_q   <= 2'd0;
      result_ok_q  <= 1'b0;
      cnt_q        <= 32'd0;
      prog_q       <= 1'b0;
      pw_updated_q <= 1'b0;
      ledg_q       <= 1'b0;
      ledr_q       <= 1'b0;
    end else begin
      pw_updated_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_pulse == 4'b1000) begin
            entry_q[15:12] <= USERIN;
            prog_q         <= mode_set;  // mode is frozen for the rest of the entry
            state_q        <= S_D3;
          end
        end
        S_D3: begin
          if (key_pulse == 4'b0100) begin
            entry_q[11:8] <= USERIN;
            state_q       <= S_D2;
          end
        end
        S_D2: begin
          if (key_pulse == 4'b0010) begin
            entry_q[7:4] <= USERIN;
            state_q      <= S_D1;
          end
        end
        S_D1: begin
          if (key_pulse == 4'b0001) begin
            entry_q[3:0] <= USERIN;
            state_q      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (check_pass_d) begin
            result_ok_q <= 1'b1;
            ledg_q      <= 1'b1;
            ledr_q      <= 1'b0;
            cnt_q       <= RESULT_RELOAD;
            state_q     <= S_RESULT;
            if (prog_q) begin
              // Programming consumes the armed permission; the failure count is untouched.
              stored_pw_q  <= entry_q;
              pw_updated_q <= 1'b1;
              armed_q      <= 1'b0;
            end else begin
              armed_q    <= 1'b1;
              fail_cnt_q <= 2'd0;
            end
          end else begin
            result_ok_q <= 1'b0;
            armed_q     <= 1'b0;
            fail_cnt_q  <= fail_inc_d;
            ledg_q      <= 1'b0;
            ledr_q      <= 1'b1;
            if (fail_inc_d == MAX_FAIL_C) begin
              cnt_q   <= LOCK_RELOAD;
              state_q <= S_LOCKOUT;
            end else begin
              cnt_q   <= RESULT_RELOAD;
              state_q <= S_RESULT;
            end
          end
        end
        S_RESULT, S_LOCKOUT: begin
          if (cnt_q == 32'd0) begin
            if (state_q == S_LOCKOUT) begin
              fail_cnt_q <= 2'd0;
            end
            entry_q <= 16'h0000;
            ledg_q  <= 1'b0;
            ledr_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign entry      = entry_q;
  assign stored_pw  = stored_pw_q;
  assign ledg       = ledg_q;
  assign ledr       = ledr_q;
  assign armed      = armed_q;
  assign pw_updated = pw_updated_q;
  assign fail_cnt   = fail_cnt_q;
  assign state_o    = state_q;

endmodule
